tl_ul_sram_responder: RTL
=========================

Name: tl_ul_sram_responder

Overview:
- TileLink-UL responder (slave/manager end) for the A/D channel pair that the core's TL monitors check.
- Accepts single-beat Get / PutFullData / PutPartialData on channel A.
- Services each request from a small byte-maskable register memory.
- Returns AccessAck / AccessAckData on channel D after a fixed latency.
- Used as a bench-side and integration target memory behind the E21 system port.

Parameters:
- ADDR_W, 31, A-channel address width.
- SRC_W, 3, source-ID width; echoed on d_source.
- BASE_ADDR, 31'h0800_0000, first byte address served.
- DEPTH, 64, number of 32-bit words; power of 2, ≥2.
- LATENCY, 1, cycles from A-accept to d_valid; range 1..15.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- a_valid  in  1  A-channel request valid.
- a_ready  out  1  A-channel ready.
- a_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get.
- a_param  in  3  must be 0; ignored otherwise.
- a_size  in  3  log2 bytes.
- a_source  in  SRC_W  request ID.
- a_address  in  ADDR_W  byte address.
- a_mask  in  4  byte lanes.
- a_data  in  32  write data.
- a_corrupt  in  1  write data poisoned.
- d_valid  out  1  response valid.
- d_ready  in  1  response accepted.
- d_opcode  out  3  0=AccessAck, 1=AccessAckData.
- d_param  out  2  always 0.
- d_size  out  3  echo of a_size.
- d_source  out  SRC_W  echo of a_source.
- d_sink  out  1  always 0.
- d_denied  out  1  request refused.
- d_data  out  32  read data; 0 for AccessAck.
- d_corrupt  out  1  data invalid.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - All outputs 0: a_ready=0, d_valid=0, all d_* fields 0.
  - Memory cleared to 0.
  - a_ready is registered and rises on the first clock edge after reset_n deasserts.
- FSM IDLE -> WAIT -> RESP -> IDLE.
  - IDLE: a_ready=1. Fire = a_valid & a_ready.
    - Capture opcode→d_opcode, size, source.
    - Compute denied (rules below).
    - Perform the write or the read in the fire cycle.
    - Load counter with LATENCY-1, then go to WAIT; go directly to RESP if LATENCY=1.
  - WAIT: a_ready=0; counter decrements each cycle; at 0 go to RESP.
  - RESP: d_valid=1; all d_* fields held stable until d_ready. On d_valid & d_ready go to IDLE; a_ready=1 the next cycle.
- Timing and throughput:
  - d_valid rises exactly LATENCY cycles after the A fire edge.
  - One outstanding transaction; throughput is one request per LATENCY+1 cycles minimum.
- Address decode:
  - off = a_address - BASE_ADDR.
  - in_range = off < DEPTH*4.
  - Word index = off[2 +: log2(DEPTH)].
- Denied when any of:
  - a_opcode not in {0,1,4} → AccessAck returned.
  - a_size > 2.
  - Address misaligned to a_size.
  - Out of range (see Optional Feature).
- Denied requests:
  - Never write memory.
  - Get returns d_data=0, d_corrupt=1.
  - Put returns d_corrupt=0.
- Put:
  - Bytes with a_mask[i]=1 are written.
  - a_corrupt=1 still writes; corruption is not stored.
  - d_opcode=0, d_data=0.
- Get:
  - d_data = full word at the index, regardless of mask.
  - d_corrupt=0.
- Read-after-write: the second access sees the new data (serialized by the single outstanding transaction).
- Reset mid-transaction: response discarded; d_valid drops immediately, asynchronously.

Optional Feature:
- Macro: TL_RESP_DENY_EN.
- Defined: out-of-range addresses are denied (d_denied=1, no write; Get sets d_corrupt=1).
- Undefined: in_range is forced to 1, so addresses alias modulo DEPTH*4 and d_denied is set only for bad opcode, size or alignment.

Decomposition:
- Package tl_ul_pkg:
  - A-opcode localparams: PUT_FULL=0, PUT_PARTIAL=1, GET=4.
  - D-opcode localparams: ACCESS_ACK=0, ACCESS_ACK_DATA=1.
  - resp_state_t enum {IDLE, WAIT, RESP}.
  - Helper function for aligned(size, addr).
- Sub-module tl_ul_resp_mem:
  - DEPTH×32 array with byte-mask write port and combinational read port.
  - Async active-low clear.

Test Plan:
- Reset then PutFull addr 0x0800_0004, data 0xDEADBEEF, mask 0xF, source 2 → D after 1 cycle: opcode 0, source 2, denied 0; then Get same addr → opcode 1, data 0xDEADBEEF.
- PutPartial mask 0x5, data 0x11223344 onto word 0xDEADBEEF → Get returns 0xDE22BE44.
- LATENCY=4, hold d_ready=0 for 3 cycles → d_valid at +4 cycles, fields stable while stalled, a_ready=0 until the cycle after d fire.
- Get size=3, then Get addr 0x0800_0002 size=2, then opcode 2 → all return d_denied=1; Gets return d_corrupt=1.
- Get addr 0x0800_0100 (DEPTH=64): with TL_RESP_DENY_EN → denied=1; without → data equals word 0.
- Assert reset_n low while in WAIT → d_valid stays 0, a_ready=0, memory reads 0 after release.

Source files
------------

// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL opcodes, responder FSM states and the alignment helper.
package tl_ul_pkg;
  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] GET             = 3'd4;
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;

  // A size of 2^size bytes must start on a 2^size byte boundary; sizes above a word never align.
  function automatic logic aligned(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      3'd0:    aligned = 1'b1;
      3'd1:    aligned = ~addr_lo[0];
      3'd2:    aligned = (addr_lo == 2'b00);
      default: aligned = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/tl_ul_resp_mem.sv
// DEPTH x 32 register memory: byte-masked synchronous write, combinational read, async clear.
module tl_ul_resp_mem #(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [3:0]       mask_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);
  logic [DEPTH-1:0][3:0][7:0] mem_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
    end else if (we_i) begin
      for (int b = 0; b < 4; b++)
        if (mask_i[b]) mem_q[idx_i][b] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_o = mem_q[idx_i];
endmodule

// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL single-outstanding responder backed by tl_ul_resp_mem.
// Define TL_RESP_DENY_EN to deny out-of-range addresses; otherwise they alias modulo DEPTH*4.
module tl_ul_sram_responder
  import tl_ul_pkg::*;
#(
  parameter int              ADDR_W    = 31,
  parameter int              SRC_W     = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 31'h0800_0000,
  parameter int              DEPTH     = 64,
  parameter int              LATENCY   = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [2:0]        a_opcode,
  input  logic [2:0]        a_param,
  input  logic [2:0]        a_size,
  input  logic [SRC_W-1:0]  a_source,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [3:0]        a_mask,
  input  logic [31:0]       a_data,
  input  logic              a_corrupt,
  output logic              d_valid,
  input  logic              d_ready,
  output logic [2:0]        d_opcode,
  output logic [1:0]        d_param,
  output logic [2:0]        d_size,
  output logic [SRC_W-1:0]  d_source,
  output logic              d_sink,
  output logic              d_denied,
  output logic [31:0]       d_data,
  output logic              d_corrupt
);
  localparam int IDX_W = $clog2(DEPTH);

  resp_state_t       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              a_ready_q;
  logic [2:0]        d_opcode_q, d_opcode_d, d_size_q, d_size_d;
  logic [SRC_W-1:0]  d_source_q, d_source_d;
  logic              d_denied_q, d_denied_d, d_corrupt_q, d_corrupt_d;
  logic [31:0]       d_data_q, d_data_d, rdata;
  logic [ADDR_W-1:0] off;
  logic              in_range, op_ok, is_get, denied, fire, mem_we;

  // Payload bits are unused by a register memory; param and corrupt never affect state.
  logic unused_a;
  assign unused_a = ^{a_param, a_corrupt};

  assign off = a_address - BASE_ADDR;
`ifdef TL_RESP_DENY_EN
  assign in_range = (off < ADDR_W'(DEPTH * 4));
`else
  assign in_range = 1'b1;
`endif
  assign op_ok  = (a_opcode == PUT_FULL) || (a_opcode == PUT_PARTIAL) || (a_opcode == GET);
  assign is_get = (a_opcode == GET);
  assign denied = !op_ok || (a_size > 3'd2) || !aligned(a_size, a_address[1:0]) || !in_range;
  assign fire   = a_valid && a_ready_q;
  assign mem_we = fire && !denied && !is_get;

  tl_ul_resp_mem #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_mem (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .we_i    (mem_we),
    .idx_i   (off[2 +: IDX_W]),
    .mask_i  (a_mask),
    .wdata_i (a_data),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    d_opcode_d  = d_opcode_q;
    d_size_d    = d_size_q;
    d_source_d  = d_source_q;
    d_denied_d  = d_denied_q;
    d_data_d    = d_data_q;
    d_corrupt_d = d_corrupt_q;
    case (state_q)
      IDLE: if (fire) begin
        d_opcode_d  = is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
        d_size_d    = a_size;
        d_source_d  = a_source;
        d_denied_d  = denied;
        d_data_d    = (is_get && !denied) ? rdata : 32'd0;
        d_corrupt_d = is_get && denied;
        cnt_d       = 4'(LATENCY - 1);
        state_d     = (LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) state_d = RESP;
      end
      RESP: if (d_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_ready_q   <= 1'b0;
      d_opcode_q  <= '0;
      d_size_q    <= '0;
      d_source_q  <= '0;
      d_denied_q  <= 1'b0;
      d_data_q    <= '0;
      d_corrupt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_ready_q   <= (state_d == IDLE);
      d_opcode_q  <= d_opcode_d;
      d_size_q    <= d_size_d;
      d_source_q  <= d_source_d;
      d_denied_q  <= d_denied_d;
      d_data_q    <= d_data_d;
      d_corrupt_q <= d_corrupt_d;
    end
  end

  assign a_ready   = a_ready_q;
  assign d_valid   = (state_q == RESP);
  assign d_opcode  = d_opcode_q;
  assign d_param   = 2'd0;
  assign d_size    = d_size_q;
  assign d_source  = d_source_q;
  assign d_sink    = 1'b0;
  assign d_denied  = d_denied_q;
  assign d_data    = d_data_q;
  assign d_corrupt = d_corrupt_q;
endmodule
